// File: rtl/lcd_init_seq_pkg.sv
// ILI9341 power-up types, opcodes and the init command/data table.
package pkg_ili9341;

   typedef enum logic [1:0] {
      CMD   = 2'd0,
      DATA  = 2'd1,
      DELAY = 2'd2,
      END   = 2'd3
   } init_kind_t;

   typedef struct packed {
      init_kind_t  kind;
      logic [7:0]  payload;
   } init_entry_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RST_REQ  = 3'd1,
      S_RST_WAIT = 3'd2,
      S_FETCH    = 3'd3,
      S_SEND     = 3'd4,
      S_DELAY    = 3'd5,
      S_DONE     = 3'd6,
      S_ERROR    = 3'd7
   } lcd_state_t;

   localparam logic [7:0] SWRESET = 8'h01;
   localparam logic [7:0] SLPOUT  = 8'h11;
   localparam logic [7:0] DISPON  = 8'h29;
   localparam logic [7:0] PIXFMT  = 8'h3A;
   localparam logic [7:0] MADCTL  = 8'h36;

   localparam init_entry_t ENTRY_END = '{kind: END, payload: 8'h00};

   // Delay payloads are in ms; entries past INIT_LEN read back as END.
   localparam int unsigned INIT_LEN = 32'd12;
   localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
      '{CMD,   SWRESET},
      '{DELAY, 8'd5},
      '{CMD,   SLPOUT},
      '{DELAY, 8'd120},
      '{CMD,   PIXFMT},
      '{DATA,  8'h55},
      '{CMD,   MADCTL},
      '{DATA,  8'h48},
      '{DELAY, 8'd0},
      '{CMD,   DISPON},
      '{DELAY, 8'd20},
      '{END,   8'h00}
   };

endpackage

// File: rtl/lcd_init_seq_rom.sv
// Combinational init-table lookup: idx -> {kind, payload}.
module lcd_init_rom
   import pkg_ili9341::*;
#(
   parameter int unsigned ROM_DEPTH = 32'd64
) (
   input  logic [$clog2(ROM_DEPTH)-1:0] i_idx,
   output logic [9:0]                   o_entry
);

   localparam int unsigned IDX_W = $clog2(ROM_DEPTH);
   localparam int unsigned SEL_W = $clog2(INIT_LEN);

   always_comb begin
      o_entry = ENTRY_END;
      if (i_idx < IDX_W'(INIT_LEN)) begin
         o_entry = INIT_TABLE[i_idx[SEL_W-1:0]];
      end else begin
         o_entry = ENTRY_END;
      end
   end

endmodule

// File: rtl/lcd_init_seq.sv
// ILI9341 power-up sequencer: panel reset handshake, then init table streaming.
// Optional watchdog (RST_WAIT/SEND stall -> ERROR) enabled by LCD_INIT_TIMEOUT_EN.
module lcd_init_seq
   import pkg_ili9341::*;
#(
   parameter int unsigned MS_CYCLES = 32'd4000,
   parameter int unsigned ROM_DEPTH = 32'd64
`ifdef LCD_INIT_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 32'd400000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   output logic       o_reset_ena,
   output logic       o_reset_val,
   input  logic       i_reset_sent,
   output logic       o_tx_valid,
   output logic [7:0] o_tx_data,
   output logic       o_tx_dc,
   input  logic       i_tx_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error
);

   localparam int unsigned IDX_W = $clog2(ROM_DEPTH);
   localparam int unsigned CNT_W = $clog2(32'd255 * MS_CYCLES);

   lcd_state_t        r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_cnt;
   logic [9:0]        w_entry_bits;
   init_entry_t       w_entry;
   logic              w_last;
   logic [CNT_W-1:0]  w_delay_load;
   logic              w_wd_hit;

   lcd_init_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (
      .i_idx   (r_idx),
      .o_entry (w_entry_bits)
   );

   assign w_entry      = w_entry_bits;
   assign w_last       = (r_idx == IDX_W'(ROM_DEPTH - 32'd1));
   assign w_delay_load = CNT_W'(w_entry.payload) * CNT_W'(MS_CYCLES) - CNT_W'(1);

`ifdef LCD_INIT_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 32'd1);
   logic [WD_W-1:0] r_wdog;

   assign w_wd_hit = (r_wdog == WD_W'(TIMEOUT_CYC - 32'd1));

   // RST_WAIT and SEND are never adjacent, so clearing outside them restarts it per state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog <= WD_W'(0);
      end else if (r_state == S_RST_WAIT || r_state == S_SEND) begin
         r_wdog <= r_wdog + WD_W'(1);
      end else begin
         r_wdog <= WD_W'(0);
      end
   end
`else
   assign w_wd_hit = 1'b0;
`endif

   // Sequencer FSM with delay counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= IDX_W'(0);
         r_cnt       <= CNT_W'(0);
         o_reset_ena <= 1'b0;
         o_reset_val <= 1'b1;
         o_tx_valid  <= 1'b0;
         o_tx_data   <= 8'h00;
         o_tx_dc     <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
      end else begin
         o_reset_ena <= 1'b0;
         o_reset_val <= 1'b1;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  r_state     <= S_RST_REQ;
                  r_idx       <= IDX_W'(0);
                  o_reset_ena <= 1'b1;
                  o_reset_val <= 1'b0;
                  o_busy      <= 1'b1;
                  o_done      <= 1'b0;
                  o_error     <= 1'b0;
               end else begin
                  r_state <= r_state;
               end
            end
            S_RST_REQ: begin
               r_state <= S_RST_WAIT;
            end
            S_RST_WAIT: begin
               if (i_reset_sent) begin
                  r_state <= S_FETCH;
               end else if (w_wd_hit) begin
                  r_state <= S_ERROR;
                  o_busy  <= 1'b0;
                  o_error <= 1'b1;
               end else begin
                  r_state <= S_RST_WAIT;
               end
            end
            S_FETCH: begin
               case (w_entry.kind)
                  CMD, DATA: begin
                     r_state    <= S_SEND;
                     o_tx_valid <= 1'b1;
                     o_tx_data  <= w_entry.payload;
                     o_tx_dc    <= (w_entry.kind == DATA);
                  end
                  DELAY: begin
                     if (w_entry.payload != 8'h00) begin
                        r_cnt   <= w_delay_load;
                        r_state <= S_DELAY;
                     end else if (w_last) begin
                        r_state <= S_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                     end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_FETCH;
                     end
                  end
                  default: begin
                     r_state <= S_DONE;
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                  end
               endcase
            end
            S_SEND: begin
               if (o_tx_valid && i_tx_ready) begin
                  o_tx_valid <= 1'b0;
                  if (w_last) begin
                     r_state <= S_DONE;
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= S_FETCH;
                  end
               end else if (w_wd_hit) begin
                  r_state    <= S_ERROR;
                  o_tx_valid <= 1'b0;
                  o_busy     <= 1'b0;
                  o_error    <= 1'b1;
               end else begin
                  r_state <= S_SEND;
               end
            end
            S_DELAY: begin
               if (r_cnt != CNT_W'(0)) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (w_last) begin
                  r_state <= S_DONE;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
